// File: rtl/key_event_pkg.sv
// Shared types and default configuration for the push-button front end.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    DB_REL   = 3'd4
  } key_state_e;

  // Per-button event bundle handed from each key_fsm to the top.
  typedef struct packed {
    logic press;
    logic rel;
    logic rpt;
    logic level;
    logic lng;
  } key_evt_t;

  localparam int DEF_NUM_SW       = 3;
  localparam int DEF_CLK_HZ       = 50_000_000;
  localparam int DEF_TICK_HZ      = 100;
  localparam int DEF_DB_TICKS     = 2;
  localparam int DEF_LONG_TICKS   = 100;
  localparam int DEF_REPEAT_TICKS = 20;

endpackage

// File: rtl/key_fsm.sv
// Per-button debounce / long-press / auto-repeat state machine, advanced on tick.
// Auto-repeat counter exists only when KEY_EVENT_REPEAT_EN is defined.
module key_fsm
  import key_event_pkg::*;
#(
  parameter int DB_TICKS     = DEF_DB_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     s,
  output key_evt_t evt
);

  localparam int DBW = $clog2(DB_TICKS + 1);
  localparam int HW  = $clog2(LONG_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_TICKS - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_TICKS - 1);

  key_state_e     state, state_n, ret, ret_n;
  logic [DBW-1:0] db_cnt, db_n;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic           press_q, press_n, rel_q, rel_n;

`ifdef KEY_EVENT_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt, rep_n;
  logic          rpt_q, rpt_n;
`endif

  always_comb begin
    state_n = state;
    ret_n   = ret;
    db_n    = db_cnt;
    hold_n  = hold_cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    rep_n   = rep_cnt;
    rpt_n   = 1'b0;
`endif
    if (tick) begin
      case (state)
        IDLE: if (s) begin
          if (DB_TICKS == 1) begin
            state_n = HELD;
            press_n = 1'b1;
            hold_n  = '0;
          end else begin
            state_n = DB_PRESS;
            db_n    = DBW'(1);
          end
        end
        DB_PRESS: begin
          if (!s) state_n = IDLE;
          else if (db_cnt == DB_LAST) begin
            state_n = HELD;
            press_n = 1'b1;
            hold_n  = '0;
          end else db_n = db_cnt + 1'b1;
        end
        HELD, LONG: begin
          if (!s) begin
            // Single-sample debounce accepts the release on the first low sample.
            if (DB_TICKS == 1) begin
              state_n = IDLE;
              rel_n   = 1'b1;
            end else begin
              state_n = DB_REL;
              db_n    = DBW'(1);
              ret_n   = state;
            end
          end else if (state == HELD) begin
            if (hold_cnt == HOLD_LAST) begin
              state_n = LONG;
`ifdef KEY_EVENT_REPEAT_EN
              rpt_n   = 1'b1;
              rep_n   = '0;
`endif
            end else hold_n = hold_cnt + 1'b1;
          end else begin
`ifdef KEY_EVENT_REPEAT_EN
            if (rep_cnt == REP_LAST) begin
              rpt_n = 1'b1;
              rep_n = '0;
            end else rep_n = rep_cnt + 1'b1;
`endif
          end
        end
        DB_REL: begin
          // A bounce back to pressed resumes with hold/repeat counts untouched.
          if (s) state_n = ret;
          else if (db_cnt == DB_LAST) begin
            state_n = IDLE;
            rel_n   = 1'b1;
          end else db_n = db_cnt + 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ret      <= IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      rep_cnt  <= '0;
      rpt_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      ret      <= ret_n;
      db_cnt   <= db_n;
      hold_cnt <= hold_n;
      press_q  <= press_n;
      rel_q    <= rel_n;
`ifdef KEY_EVENT_REPEAT_EN
      rep_cnt  <= rep_n;
      rpt_q    <= rpt_n;
`endif
    end
  end

  assign evt.press = press_q;
  assign evt.rel   = rel_q;
`ifdef KEY_EVENT_REPEAT_EN
  assign evt.rpt   = rpt_q;
`else
  assign evt.rpt   = 1'b0;
`endif
  assign evt.level = (state == HELD) || (state == LONG) || (state == DB_REL);
  assign evt.lng   = (state == LONG) || ((state == DB_REL) && (ret == LONG));

endmodule

// File: rtl/key_event.sv
// Button front end: 2-flop synchroniser, shared sample-tick divider, one key_fsm per button.
// Auto-repeat pulses enabled by defining KEY_EVENT_REPEAT_EN.
module key_event
  import key_event_pkg::*;
#(
  parameter int NUM_SW       = DEF_NUM_SW,
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int TICK_HZ      = DEF_TICK_HZ,
  parameter int DB_TICKS     = DEF_DB_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] i_sw,
  output logic [NUM_SW-1:0] o_press,
  output logic [NUM_SW-1:0] o_release,
  output logic [NUM_SW-1:0] o_repeat,
  output logic [NUM_SW-1:0] o_level,
  output logic [NUM_SW-1:0] o_long
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [NUM_SW-1:0]              s_meta, s_sync;
  logic [DW-1:0]                  div_cnt;
  logic                           tick;
  key_evt_t [NUM_SW-1:0]          evt;

  assign tick = (div_cnt == DIV_LAST);

  // Buttons are active-low; inversion happens ahead of the first flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta  <= '0;
      s_sync  <= '0;
      div_cnt <= '0;
    end else begin
      s_meta  <= ~i_sw;
      s_sync  <= s_meta;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SW; g++) begin : g_key
    key_fsm #(
      .DB_TICKS     (DB_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_fsm (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .s    (s_sync[g]),
      .evt  (evt[g])
    );
    assign o_press[g]   = evt[g].press;
    assign o_release[g] = evt[g].rel;
    assign o_repeat[g]  = evt[g].rpt;
    assign o_level[g]   = evt[g].level;
    assign o_long[g]    = evt[g].lng;
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: DIV=10, DB_TICKS=2, LONG_TICKS=5, REPEAT_TICKS=3.
module tb_key_event;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] i_sw = 3'b111;
  logic [2:0] o_press, o_release, o_repeat, o_level, o_long;

  int pass_cnt = 0;
  int total_cnt = 0;

  key_event #(
    .NUM_SW(3), .CLK_HZ(1000), .TICK_HZ(100),
    .DB_TICKS(2), .LONG_TICKS(5), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .i_sw(i_sw),
    .o_press(o_press), .o_release(o_release), .o_repeat(o_repeat),
    .o_level(o_level), .o_long(o_long)
  );

  always #5 clk = ~clk;

  // Independent tick model: tick_edge is high just after an edge that was a tick.
  int   bdiv = 0;
  logic tick_edge = 1'b0;
  always @(posedge clk) begin
    if (rst) bdiv <= 0;
    else     bdiv <= (bdiv == 9) ? 0 : bdiv + 1;
    tick_edge <= !rst && (bdiv == 9);
  end

  // Pulse counters and width monitor.
  int press_cnt[3], rel_cnt[3], rpt_cnt[3];
  int width_err = 0;
  logic [2:0] prev_p = '0, prev_r = '0, prev_t = '0;
  initial for (int i = 0; i < 3; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; rpt_cnt[i] = 0; end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      press_cnt[i] <= press_cnt[i] + int'(o_press[i]);
      rel_cnt[i]   <= rel_cnt[i]   + int'(o_release[i]);
      rpt_cnt[i]   <= rpt_cnt[i]   + int'(o_repeat[i]);
    end
    if (((o_press & prev_p) | (o_release & prev_r) | (o_repeat & prev_t)) != 3'b000)
      width_err <= width_err + 1;
    prev_p <= o_press;
    prev_r <= o_release;
    prev_t <= o_repeat;
  end

  task automatic do_reset(input logic [2:0] sw);
    @(negedge clk); rst = 1'b1; i_sw = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0; i_sw = sw;
  endtask

  task automatic next_tick();
    int g = 0;
    do begin @(posedge clk); #1; g++; end while (!tick_edge && g < 20);
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; i_sw = 3'b000;
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if ({o_press, o_release, o_repeat, o_level, o_long} !== 15'h0)
      $display("FAIL reset_outputs got %h want 0", {o_press, o_release, o_repeat, o_level, o_long});
    else pass_cnt++;
  endtask

  task automatic test_press();
    do_reset(3'b110);
    next_tick();
    total_cnt++;
    if ({o_press, o_level} !== 6'b0) $display("FAIL press_t1 got %b want 000000", {o_press, o_level});
    else pass_cnt++;
    next_tick();
    total_cnt++;
    if (o_press !== 3'b001) $display("FAIL press_t2 got %b want 001", o_press); else pass_cnt++;
    total_cnt++;
    if (o_level !== 3'b001) $display("FAIL level_t2 got %b want 001", o_level); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({o_press, o_release, o_repeat, o_long} !== 12'h0)
      $display("FAIL press_width got %h want 0", {o_press, o_release, o_repeat, o_long});
    else pass_cnt++;
  endtask

  // Runs on from test_press with sw0 still held.
  task automatic test_glitch();
    int p0;
    p0 = press_cnt[1];
    next_tick();
    i_sw[1] = 1'b0;
    repeat (12) @(posedge clk);
    #1 i_sw[1] = 1'b1;
    next_tick(); next_tick(); next_tick();
    total_cnt++;
    if (press_cnt[1] != p0) $display("FAIL glitch_press got %0d want %0d", press_cnt[1], p0);
    else pass_cnt++;
    total_cnt++;
    if (o_level !== 3'b001) $display("FAIL glitch_level got %b want 001", o_level); else pass_cnt++;
  endtask

  task automatic test_long();
    int r0, exp_total;
    logic exp_rpt;
    do_reset(3'b110);
    r0 = rpt_cnt[0];
    for (int t = 1; t <= 15; t++) begin
      next_tick();
`ifdef KEY_EVENT_REPEAT_EN
      exp_rpt = (t == 7) || (t == 10) || (t == 13);
`else
      exp_rpt = 1'b0;
`endif
      total_cnt++;
      if (o_long[0] !== (t >= 7)) $display("FAIL long_t%0d got %b want %b", t, o_long[0], (t >= 7));
      else pass_cnt++;
      total_cnt++;
      if (o_repeat[0] !== exp_rpt) $display("FAIL repeat_t%0d got %b want %b", t, o_repeat[0], exp_rpt);
      else pass_cnt++;
    end
`ifdef KEY_EVENT_REPEAT_EN
    exp_total = 3;
`else
    exp_total = 0;
`endif
    total_cnt++;
    if (rpt_cnt[0] - r0 != exp_total)
      $display("FAIL repeat_total got %0d want %0d", rpt_cnt[0] - r0, exp_total);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int r0;
    do_reset(3'b110);
    for (int t = 1; t <= 4; t++) next_tick();
    r0 = rel_cnt[0];
    i_sw[0] = 1'b1;
    next_tick();
    total_cnt++;
    if (o_level[0] !== 1'b1) $display("FAIL bounce_level got %b want 1", o_level[0]); else pass_cnt++;
    i_sw[0] = 1'b0;
    next_tick(); next_tick(); next_tick();
    total_cnt++;
    if (o_long[0] !== 1'b0) $display("FAIL resume_early got %b want 0", o_long[0]); else pass_cnt++;
    next_tick();
    total_cnt++;
    if (o_long[0] !== 1'b1) $display("FAIL resume_long got %b want 1", o_long[0]); else pass_cnt++;
    total_cnt++;
    if (rel_cnt[0] != r0) $display("FAIL bounce_release got %0d want %0d", rel_cnt[0], r0); else pass_cnt++;
    i_sw[0] = 1'b1;
    next_tick();
    total_cnt++;
    if ({o_release[0], o_level[0], o_long[0]} !== 3'b011)
      $display("FAIL dbrel_state got %b want 011", {o_release[0], o_level[0], o_long[0]});
    else pass_cnt++;
    next_tick();
    total_cnt++;
    if ({o_release, o_level[0], o_long[0]} !== 5'b00100)
      $display("FAIL release_pulse got %b want 00100", {o_release, o_level[0], o_long[0]});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (o_release !== 3'b000) $display("FAIL release_width got %b want 000", o_release); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    do_reset(3'b110);
    for (int t = 1; t <= 8; t++) next_tick();
    total_cnt++;
    if (o_long[0] !== 1'b1) $display("FAIL pre_rst_long got %b want 1", o_long[0]); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total_cnt++;
    if ({o_press, o_release, o_repeat, o_level, o_long} !== 15'h0)
      $display("FAIL rst_mid_outputs got %h want 0", {o_press, o_release, o_repeat, o_level, o_long});
    else pass_cnt++;
    next_tick(); next_tick();
    total_cnt++;
    if (o_press !== 3'b001) $display("FAIL rst_repress got %b want 001", o_press); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_long();
    test_bounce();
    test_rst_mid();
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if (width_err != 0) $display("FAIL pulse_width got %0d wide pulses want 0", width_err);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
